// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are captured at issue; the result is written on the last busy cycle.
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             req,
  output logic             busy,
  output logic             start,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int W2      = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             is_muldiv, signed_mul, signed_div, a_neg, b_neg;
  logic [W2-1:0]    ext_a, ext_b, prod, acc;
  logic [WIDTH-1:0] abs_a, abs_b, q_mag, r_mag, quo, rem;

  assign is_muldiv = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                                OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  assign busy  = (cnt_q != '0);
  assign start = is_muldiv & ~busy & ~req;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Sign/zero extension to 2*WIDTH makes one unsigned multiplier serve both flavours.
  assign signed_mul = op_q inside {OP_MULT, OP_MADD, OP_MSUB};
  assign ext_a = signed_mul ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b = signed_mul ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;
  assign acc   = {hi_q, lo_q};

  // Signed divide via magnitudes; most-negative / -1 wraps to most-negative naturally.
  assign signed_div = (op_q == OP_DIV);
  assign a_neg = signed_div & a_q[WIDTH-1];
  assign b_neg = signed_div & b_q[WIDTH-1];
  assign abs_a = a_neg ? -a_q : a_q;
  assign abs_b = b_neg ? -b_q : b_q;
  assign q_mag = (abs_b != '0) ? abs_a / abs_b : '0;
  assign r_mag = (abs_b != '0) ? abs_a % abs_b : '0;
  assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (busy) begin
      if (cnt_q == CW'(1)) begin
        cnt_d = '0;
        case (op_q)
          OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
          OP_MADD, OP_MADDU: {hi_d, lo_d} = acc + prod;
          OP_MSUB, OP_MSUBU: {hi_d, lo_d} = acc - prod;
          OP_DIV, OP_DIVU: begin
            if (b_q != '0) begin
              hi_d = rem;
              lo_d = quo;
            end
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (!req) begin
      if (start) begin
        a_d   = a;
        b_d   = b;
        op_d  = op;
        cnt_d = (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end else if (op == OP_MTHI) begin
        hi_d = a;
      end else if (op == OP_MTLO) begin
        lo_d = a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit with a few hand-written multi-cycle sequences.
module tb_muldiv_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic        clk, reset, req, busy, start;
  logic [31:0] a, b, hi, lo;
  logic [3:0]  op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  muldiv_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .req(req),
    .busy(busy), .start(start), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    op = OP_MTHI; a = h; step();
    op = OP_MTLO; a = l; step();
    op = OP_NONE;
  endtask

  task automatic run_issue(input string name, input logic [3:0] o,
                           input logic [31:0] av, input logic [31:0] bv, output int n);
    op = o; a = av; b = bv;
    #1;
    chk({name, "_start"}, {31'd0, start}, 32'd1);
    step();
    op = OP_NONE;
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h0,        32'h0,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{OP_DIVU,  32'd7,        32'd0,        32'h0000AAAA, 32'h00005555, 32'h0000AAAA, 32'h00005555, 10};
    vecs[4]  = '{OP_MADD,  32'h00010000, 32'h00010000, 32'h12345678, 32'h0,        32'h12345679, 32'h00000000, 5};
    vecs[5]  = '{OP_MSUBU, 32'h00010000, 32'h00010000, 32'h12345679, 32'h0,        32'h12345678, 32'h00000000, 5};
    vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1,        32'h1,        32'h00000000, 32'h80000000, 10};
    vecs[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'h0,        32'h0,        32'h00000002, 32'h0000000E, 10};
    vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{OP_MSUB,  32'd2,        32'd3,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[10] = '{OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5};
    vecs[11] = '{OP_MADD,  32'hFFFFFFFF, 32'd1,        32'h0,        32'd5,        32'h00000000, 32'h00000004, 5};
    vecs[12] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h0,        32'h0,        32'h40000000, 32'h00000000, 5};
    vecs[13] = '{OP_DIV,   32'hFFFFFFF8, 32'd3,        32'h0,        32'h0,        32'hFFFFFFFE, 32'hFFFFFFFE, 10};

    reset = 1'b1; req = 1'b0; op = OP_NONE; a = '0; b = '0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    step();

    op = OP_MTHI; a = 32'hDEADBEEF;
    #1;
    chk("mthi_no_start", {31'd0, start}, 32'd0);
    step();
    op = OP_NONE;
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'hDEADBEEF);

    for (int i = 0; i < 14; i++) begin
      preload(vecs[i].pre_hi, vecs[i].pre_lo);
      run_issue($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk($sformatf("v%0d_lat", i), n, vecs[i].lat);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // Operands, op and mthi change every busy cycle; result must use issue-time values.
    preload(32'h0, 32'h0);
    op = OP_MULT; a = 32'd6; b = 32'd7;
    #1;
    chk("hold_start", {31'd0, start}, 32'd1);
    step();
    n = 0;
    while (busy && n < 100) begin
      n++;
      op = (n % 2 == 1) ? OP_MULT : OP_MTHI;
      a = $urandom;
      b = $urandom;
      #1;
      chk($sformatf("hold_nostart%0d", n), {31'd0, start}, 32'd0);
      step();
    end
    op = OP_NONE;
    chk("hold_lat", n, 5);
    chk("hold_hi", hi, 32'd0);
    chk("hold_lo", lo, 32'd42);

    // Flush request blocks issue and mthi/mtlo.
    preload(32'h11, 32'h22);
    req = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd3;
    #1;
    chk("req_start", {31'd0, start}, 32'd0);
    step();
    chk("req_busy", {31'd0, busy}, 32'd0);
    op = OP_MTLO; a = 32'h99; step();
    op = OP_MTHI; a = 32'h77; step();
    req = 1'b0; op = OP_NONE;
    step(); step();
    chk("req_busy2", {31'd0, busy}, 32'd0);
    chk("req_hi", hi, 32'h11);
    chk("req_lo", lo, 32'h22);

    // Reset in the third busy cycle of a divide discards it.
    preload(32'h55, 32'h66);
    op = OP_DIV; a = 32'd100; b = 32'd7;
    step();
    op = OP_NONE;
    chk("rdiv_busy", {31'd0, busy}, 32'd1);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rdiv_busy0", {31'd0, busy}, 32'd0);
    chk("rdiv_hi0", hi, 32'd0);
    chk("rdiv_lo0", lo, 32'd0);
    repeat (15) step();
    chk("rdiv_busy_late", {31'd0, busy}, 32'd0);
    chk("rdiv_hi_late", hi, 32'd0);
    chk("rdiv_lo_late", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
